// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle for seq_pattern_tx: burst controls in, serial stream and status out.
// x_valid qualifies x_out and match_exp; there is no ready, so the stream advances every cycle x_valid is high.
interface seq_pattern_tx_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             overlap_en;
    logic             abort;
    logic             x_out;
    logic             x_valid;
    logic             match_exp;
    logic             busy;
    logic             done;

    modport master (
        output start, count, gap, overlap_en, abort,
        input  x_out, x_valid, match_exp, busy, done
    );

    modport slave (
        input  start, count, gap, overlap_en, abort,
        output x_out, x_valid, match_exp, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial transmitter emitting `count` copies of a fixed pattern, gapped, back-to-back or overlapped,
// plus the match strobe a detector for the same pattern is expected to raise.
module seq_pattern_tx #(
    parameter int             PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
    parameter int             OVL_LEN = 2,
    parameter int             CNT_W   = 8,
    parameter int             GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_pattern_tx_if.slave    bus,
    output logic [1:0]         dbg_state
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(OVL_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [GAP_W-1:0] gcnt, gcnt_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic             ovl_q, ovl_n;
    logic             done_n;

    assign dbg_state = state;

    // The state registers describe the bit shown on the outputs in the same cycle,
    // so outputs are registered from the next-state values.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        rem_n   = rem;
        gcnt_n  = gcnt;
        gap_n   = gap_q;
        ovl_n   = ovl_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort && (bus.count != '0)) begin
                    state_n = SEND;
                    idx_n   = '0;
                    rem_n   = bus.count;
                    gap_n   = bus.gap;
                    ovl_n   = bus.overlap_en;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (idx == IDX_LAST) begin
                    rem_n = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_n = GAP;
                        gcnt_n  = gap_q;
                    end else if (ovl_q) begin
                        idx_n = IDX_OVL;
                    end else begin
                        idx_n = '0;
                    end
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt - GAP_W'(1);
                    if (gcnt == GAP_W'(1)) begin
                        state_n = SEND;
                        idx_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            rem           <= '0;
            gcnt          <= '0;
            gap_q         <= '0;
            ovl_q         <= 1'b0;
            bus.x_out     <= 1'b0;
            bus.x_valid   <= 1'b0;
            bus.match_exp <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            rem           <= rem_n;
            gcnt          <= gcnt_n;
            gap_q         <= gap_n;
            ovl_q         <= ovl_n;
            bus.x_out     <= (state_n == SEND) && PATTERN[IDX_LAST - idx_n];
            bus.x_valid   <= (state_n != IDLE);
            bus.match_exp <= (state_n == SEND) && (idx_n == IDX_LAST);
            bus.busy      <= (state_n != IDLE);
            bus.done      <= done_n;
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: stream model built from the burst rules, per-cycle compare,
// and literal stream/strobe expectations for each directed burst.
module tb_seq_pattern_tx;
  localparam int PAT_W = 5;
  localparam logic [PAT_W-1:0] PAT = 5'b10110;
  localparam int OVL_LEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  seq_pattern_tx_if #(.CNT_W(8), .GAP_W(4)) bus ();

  seq_pattern_tx dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected per-cycle outputs {x_valid, x_out, match_exp, busy, done}
  logic [4:0] exp_q[$];
  logic [4:0] cur_exp = '0;

  task automatic build_burst(input int cnt, input int g, input bit ov);
    for (int k = 0; k < cnt; k++) begin
      int first_bit;
      first_bit = (k > 0 && g == 0 && ov) ? OVL_LEN : 0;
      if (k > 0)
        for (int j = 0; j < g; j++) exp_q.push_back(5'b11010 & 5'b10010);
      for (int b = first_bit; b < PAT_W; b++)
        exp_q.push_back({1'b1, PAT[PAT_W-1-b], (b == PAT_W-1), 1'b1, 1'b0});
    end
    exp_q.push_back(5'b00001);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_exp = '0;
    end else begin
      if (cur_exp[1] && bus.abort)
        exp_q.delete();
      else if (!cur_exp[1] && bus.start && !bus.abort && bus.count != 0)
        build_burst(int'(bus.count), int'(bus.gap), bus.overlap_en);
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
    end
  end

  // Per-cycle compare plus capture of the stream for literal checks
  logic [63:0] cap_bits = '0;
  logic [63:0] cap_m = '0;
  int cap_len = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    check("cycle", {59'd0, bus.x_valid, bus.x_out, bus.match_exp, bus.busy, bus.done},
          {59'd0, cur_exp});
    if (bus.x_valid) begin
      cap_bits = {cap_bits[62:0], bus.x_out};
      cap_m    = {cap_m[62:0], bus.match_exp};
      cap_len++;
    end
    if (bus.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap_bits = '0;
    cap_m    = '0;
    cap_len  = 0;
    done_cnt = 0;
  endtask

  task automatic do_start(input int cnt, input int g, input bit ov);
    bus.start      = 1'b1;
    bus.count      = 8'(cnt);
    bus.gap        = 4'(g);
    bus.overlap_en = ov;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic expect_stream(input string name, input logic [63:0] bits, input logic [63:0] m,
                               input int len, input int dones);
    check({name, "_bits"}, cap_bits, bits);
    check({name, "_match"}, cap_m, m);
    check({name, "_len"}, 64'(cap_len), 64'(len));
    check({name, "_done"}, 64'(done_cnt), 64'(dones));
  endtask

  initial begin
    bus.start = 1'b0; bus.count = '0; bus.gap = '0; bus.overlap_en = 1'b0; bus.abort = 1'b0;

    // Reset held three cycles with a start pulse inside it
    clear_cap();
    tick();
    bus.start = 1'b1; bus.count = 8'd1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("reset_outs", {59'd0, bus.x_valid, bus.x_out, bus.match_exp, bus.busy, bus.done}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    expect_stream("reset", 64'd0, 64'd0, 0, 0);

    clear_cap(); do_start(1, 0, 0); repeat (8) tick();
    expect_stream("single", 64'b10110, 64'b00001, 5, 1);

    clear_cap(); do_start(3, 0, 1); repeat (14) tick();
    expect_stream("overlap", 64'b10110110110, 64'b00001001001, 11, 1);

    clear_cap(); do_start(2, 2, 1); repeat (15) tick();
    expect_stream("gap2", 64'b101100010110, 64'b000010000001, 12, 1);

    clear_cap(); do_start(2, 0, 0); repeat (13) tick();
    expect_stream("b2b", 64'b1011010110, 64'b0000100001, 10, 1);

    clear_cap(); do_start(3, 1, 0); repeat (20) tick();
    expect_stream("gap1", 64'b10110010110010110, 64'b00001000001000001, 17, 1);

    clear_cap(); do_start(0, 0, 0); repeat (4) tick();
    expect_stream("count0", 64'd0, 64'd0, 0, 0);

    // start pulsed mid-burst is ignored
    clear_cap(); do_start(1, 0, 0); tick();
    bus.start = 1'b1; bus.count = 8'd3; bus.gap = 4'd1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    expect_stream("midstart", 64'b10110, 64'b00001, 5, 1);

    // abort together with start in IDLE
    clear_cap();
    bus.abort = 1'b1; bus.start = 1'b1; bus.count = 8'd2;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    repeat (4) tick();
    expect_stream("abort_start", 64'd0, 64'd0, 0, 0);

    // abort on the cycle showing bit 3, then a normal burst
    clear_cap(); do_start(4, 0, 0); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_next_valid", {62'd0, bus.x_valid, bus.busy}, 64'd0);
    repeat (3) tick();
    expect_stream("abort", 64'b101, 64'b000, 3, 0);
    clear_cap(); do_start(1, 0, 0); repeat (8) tick();
    expect_stream("after_abort", 64'b10110, 64'b00001, 5, 1);

    // same with reset instead of abort
    clear_cap(); do_start(4, 0, 0); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_next_valid", {62'd0, bus.x_valid, bus.busy}, 64'd0);
    repeat (3) tick();
    expect_stream("midrst", 64'b101, 64'b000, 3, 0);
    clear_cap(); do_start(1, 0, 0); repeat (8) tick();
    expect_stream("after_rst", 64'b10110, 64'b00001, 5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
